// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART load-protocol engine: command/reply bytes and FSM encodings.
package uart_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ST_W   = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [BYTE_W-1:0] CMD_W   = 8'h57;
    localparam logic [BYTE_W-1:0] CMD_R   = 8'h52;
    localparam logic [BYTE_W-1:0] CMD_G   = 8'h47;
    localparam logic [BYTE_W-1:0] CMD_H   = 8'h48;

    localparam logic [BYTE_W-1:0] RSP_K   = 8'h4B;
    localparam logic [BYTE_W-1:0] RSP_BAD = 8'h3F;
    localparam logic [BYTE_W-1:0] RSP_TO  = 8'h21;

    localparam logic [ST_W-1:0] S_IDLE    = 4'd0;
    localparam logic [ST_W-1:0] S_CMD_DEC = 4'd1;
    localparam logic [ST_W-1:0] S_ADDR    = 4'd2;
    localparam logic [ST_W-1:0] S_DATA    = 4'd3;
    localparam logic [ST_W-1:0] S_WR      = 4'd4;
    localparam logic [ST_W-1:0] S_RD_REQ  = 4'd5;
    localparam logic [ST_W-1:0] S_RD_WAIT = 4'd6;
    localparam logic [ST_W-1:0] S_HOLD    = 4'd7;
    localparam logic [ST_W-1:0] S_SEND    = 4'd8;

    // States in which the engine is allowed to pop the RX FIFO.
    function automatic logic pops_in(input logic [ST_W-1:0] s);
        return (s == S_IDLE) || (s == S_ADDR) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// FIFO-side and memory-port signals of the load engine, bundled as one interface.
interface uart_loader_if #(
    parameter int unsigned AW = 14
);
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              mem_we;
    logic              mem_re;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              cpu_hold;

    // Loader side.
    modport master (
        input  rx_empty, r_data, tx_full, mem_rdata,
        output rd_uart, wr_uart, w_data, mem_we, mem_re, mem_addr, mem_wdata, cpu_hold
    );

    // FIFO / memory side.
    modport slave (
        output rx_empty, r_data, tx_full, mem_rdata,
        input  rd_uart, wr_uart, w_data, mem_we, mem_re, mem_addr, mem_wdata, cpu_hold
    );
endinterface

// File: rtl/uart_loader_timer.sv
// Inter-byte timeout counter: counts while enabled, saturates at TIMEOUT-1.
module loader_timer #(
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired_c
);
    localparam logic [TO_BIT-1:0] LAST = TO_BIT'(TIMEOUT - 1);

    logic [TO_BIT-1:0] r_count;

    // Clear wins over counting; stop at the terminal value.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired_c) begin
            r_count <= r_count + TO_BIT'(1);
        end
    end

    assign o_expired_c = (r_count == LAST);
endmodule

// File: rtl/uart_loader.sv
// Binary load-protocol engine: decodes W/R/G/H frames from the RX FIFO, drives the
// memory port, and pushes acknowledge / read-data bytes to the TX FIFO.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int unsigned AW      = 14,
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic          clk,
    input  logic          reset,
    uart_loader_if.master bus
);
    logic [ST_W-1:0]   r_state,    w_state_nx;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nx;
    logic [BYTE_W-1:0] r_cmd,      w_cmd_nx;
    logic [23:0]       r_addr,     w_addr_nx;
    logic [WORD_W-1:0] r_reply,    w_reply_nx;
    logic [CNT_W-1:0]  r_nbytes,   w_nbytes_nx;
    logic              r_wr_uart,  w_wr_nx;
    logic [BYTE_W-1:0] r_w_data,   w_wdat_nx;
    logic              r_mem_we,   w_we_nx;
    logic              r_mem_re,   w_re_nx;
    logic [AW-1:0]     r_mem_addr, w_maddr_nx;
    logic [WORD_W-1:0] r_mem_wdata, w_mwdata_nx;
    logic              r_cpu_hold, w_hold_nx;

    logic              w_pop;
    logic              w_in_frame;
    logic              w_expired;
    logic              w_launch;
    logic [WORD_W-1:0] w_launch_word;
    logic [CNT_W-1:0]  w_launch_n;

    assign w_pop      = pops_in(r_state) && !bus.rx_empty;
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);

    loader_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BIT  (TO_BIT)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_pop || !w_in_frame),
        .i_en        (w_in_frame),
        .o_expired_c (w_expired)
    );

    // Next-state and next-output decode; a "launch" loads the reply buffer and pushes byte 0 if TX has room.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_cmd_nx      = r_cmd;
        w_addr_nx     = r_addr;
        w_reply_nx    = r_reply;
        w_nbytes_nx   = r_nbytes;
        w_wr_nx       = 1'b0;
        w_wdat_nx     = r_w_data;
        w_we_nx       = 1'b0;
        w_re_nx       = 1'b0;
        w_maddr_nx    = r_mem_addr;
        w_mwdata_nx   = r_mem_wdata;
        w_hold_nx     = r_cpu_hold;
        w_launch      = 1'b0;
        w_launch_word = '0;
        w_launch_n    = CNT_W'(1);

        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_cmd_nx   = bus.r_data;
                    w_state_nx = S_CMD_DEC;
                    // Hold changes on the pop edge so the CPU sees it one cycle after the command.
                    if (bus.r_data == CMD_G) begin
                        w_hold_nx = 1'b0;
                    end else if (bus.r_data == CMD_H) begin
                        w_hold_nx = 1'b1;
                    end
                end
            end
            S_CMD_DEC: begin
                w_cnt_nx = '0;
                case (r_cmd)
                    CMD_W, CMD_R: w_state_nx = S_ADDR;
                    CMD_G, CMD_H: begin
                        w_launch      = 1'b1;
                        w_launch_word = {24'h0, RSP_K};
                        w_state_nx    = S_HOLD;
                    end
                    default: begin
                        w_launch      = 1'b1;
                        w_launch_word = {24'h0, RSP_BAD};
                        w_state_nx    = S_SEND;
                    end
                endcase
            end
            S_ADDR: begin
                if (w_pop) begin
                    if (r_cnt == CNT_W'(3)) begin
                        w_maddr_nx = AW'({bus.r_data, r_addr} >> 2);
                        w_cnt_nx   = '0;
                        if (r_cmd == CMD_W) begin
                            w_state_nx = S_DATA;
                        end else begin
                            w_state_nx = S_RD_REQ;
                            w_re_nx    = 1'b1;
                        end
                    end else begin
                        w_addr_nx = {bus.r_data, r_addr[23:8]};
                        w_cnt_nx  = r_cnt + CNT_W'(1);
                    end
                end else if (w_expired) begin
                    w_launch      = 1'b1;
                    w_launch_word = {24'h0, RSP_TO};
                    w_state_nx    = S_SEND;
                end
            end
            S_DATA: begin
                if (w_pop) begin
                    w_mwdata_nx = {bus.r_data, r_mem_wdata[31:8]};
                    if (r_cnt == CNT_W'(3)) begin
                        w_state_nx = S_WR;
                        w_we_nx    = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end else if (w_expired) begin
                    w_launch      = 1'b1;
                    w_launch_word = {24'h0, RSP_TO};
                    w_state_nx    = S_SEND;
                end
            end
            S_WR: begin
                w_launch      = 1'b1;
                w_launch_word = {24'h0, RSP_K};
                w_state_nx    = S_SEND;
            end
            S_RD_REQ: w_state_nx = S_RD_WAIT;
            S_RD_WAIT: begin
                w_launch      = 1'b1;
                w_launch_word = bus.mem_rdata;
                w_launch_n    = CNT_W'(4);
                w_state_nx    = S_SEND;
            end
            S_HOLD: w_state_nx = S_SEND;
            S_SEND: begin
                // r_cnt counts bytes already pushed; stall while TX is full.
                if (r_cnt == r_nbytes) begin
                    w_state_nx = S_IDLE;
                end else if (!bus.tx_full) begin
                    w_wr_nx   = 1'b1;
                    w_wdat_nx = r_reply[{r_cnt[1:0], 3'b000} +: 8];
                    w_cnt_nx  = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        if (w_launch) begin
            w_reply_nx  = w_launch_word;
            w_nbytes_nx = w_launch_n;
            if (!bus.tx_full) begin
                w_wr_nx   = 1'b1;
                w_wdat_nx = w_launch_word[7:0];
                w_cnt_nx  = CNT_W'(1);
            end else begin
                w_cnt_nx  = '0;
            end
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_reply     <= '0;
            r_nbytes    <= CNT_W'(1);
            r_wr_uart   <= 1'b0;
            r_w_data    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_hold  <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_cmd       <= w_cmd_nx;
            r_addr      <= w_addr_nx;
            r_reply     <= w_reply_nx;
            r_nbytes    <= w_nbytes_nx;
            r_wr_uart   <= w_wr_nx;
            r_w_data    <= w_wdat_nx;
            r_mem_we    <= w_we_nx;
            r_mem_re    <= w_re_nx;
            r_mem_addr  <= w_maddr_nx;
            r_mem_wdata <= w_mwdata_nx;
            r_cpu_hold  <= w_hold_nx;
        end
    end

    assign bus.rd_uart   = w_pop;
    assign bus.wr_uart   = r_wr_uart;
    assign bus.w_data    = r_w_data;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_hold  = r_cpu_hold;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: RX queue feeds frames, scoreboards hold expected TX bytes and memory ops.
module tb_uart_loader;
    localparam int unsigned AW = 14;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } mem_op_t;

    logic clk;
    logic reset;

    uart_loader_if #(.AW(AW)) bus ();

    uart_loader #(
        .AW      (AW),
        .TIMEOUT (16),
        .TO_BIT  (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    mem_op_t    exp_mem[$];
    int         tx_edges[$];
    int         we_edges[$];
    int         re_edges[$];
    int         edge_n;
    int         n_pop;
    int         first_pop;
    int         last_pop;
    int         feed_edge;
    int         n_cmp;
    int         n_err;

    logic [7:0] f_w  [9] = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] f_r  [5] = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
    logic [7:0] f_rb [5] = '{8'h52, 8'h23, 8'h00, 8'h01, 8'h00};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.rx_empty = (rx_q.size() == 0);
        bus.r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic feed(input logic [7:0] b);
        rx_q.push_back(b);
        refresh();
    endtask

    task automatic start_test();
        n_pop     = 0;
        first_pop = -1;
        last_pop  = -1;
        feed_edge = edge_n;
        tx_edges.delete();
        we_edges.delete();
        re_edges.delete();
    endtask

    // One clock: model the RX pop, then check every push / memory strobe against the scoreboards.
    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = bus.rd_uart;
        @(posedge clk);
        #1;
        edge_n++;
        if (pop === 1'b1) begin
            rx_q.delete(0);
            n_pop++;
            if (n_pop == 1) first_pop = edge_n;
            last_pop = edge_n;
            refresh();
        end
        if (bus.wr_uart === 1'b1) begin
            tx_edges.push_back(edge_n);
            chk("push_while_full", 32'(bus.tx_full), 32'd0);
            n_cmp++;
            assert (exp_tx.size() != 0) else begin
                n_err++;
                $error("FAIL tx_unexpected: observed %0h expected none", bus.w_data);
            end
            if (exp_tx.size() != 0) begin
                chk("tx_byte", 32'(bus.w_data), 32'(exp_tx[0]));
                exp_tx.delete(0);
            end
        end
        if (bus.mem_we === 1'b1 || bus.mem_re === 1'b1) begin
            chk("we_re_exclusive", 32'(bus.mem_we & bus.mem_re), 32'd0);
            if (bus.mem_we === 1'b1) we_edges.push_back(edge_n);
            if (bus.mem_re === 1'b1) re_edges.push_back(edge_n);
            n_cmp++;
            assert (exp_mem.size() != 0) else begin
                n_err++;
                $error("FAIL mem_unexpected: observed we=%0b re=%0b expected none", bus.mem_we, bus.mem_re);
            end
            if (exp_mem.size() != 0) begin
                chk("mem_kind", 32'(bus.mem_we), 32'(exp_mem[0].we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_mem[0].addr));
                if (exp_mem[0].we) chk("mem_wdata", bus.mem_wdata, exp_mem[0].data);
                exp_mem.delete(0);
            end
        end
    endtask

    // Run until all queued stimulus and expectations are consumed, bounded by a cycle budget.
    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_mem.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_pending"}, 32'(rx_q.size() + exp_tx.size() + exp_mem.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_pops(input int want, input int budget);
        int n;
        n = 0;
        while (n_pop < want && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_uart"},   32'(bus.rd_uart),   32'd0);
        chk({tag, "_wr_uart"},   32'(bus.wr_uart),   32'd0);
        chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        chk({tag, "_mem_re"},    32'(bus.mem_re),    32'd0);
        chk({tag, "_w_data"},    32'(bus.w_data),    32'd0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        chk({tag, "_cpu_hold"},  32'(bus.cpu_hold),  32'd1);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        edge_n        = 0;
        reset         = 1'b1;
        bus.tx_full   = 1'b0;
        bus.mem_rdata = 32'h0;
        refresh();
        start_test();

        // Reset state.
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_values("reset");

        // Write frame, back-to-back bytes.
        start_test();
        exp_mem.push_back('{we: 1'b1, addr: 14'd4, data: 32'hDEADBEEF});
        exp_tx.push_back(8'h4B);
        foreach (f_w[i]) feed(f_w[i]);
        drain(100, "write");
        chk("write_pops",     32'(n_pop), 32'd9);
        chk("write_span",     32'(last_pop - first_pop), 32'd9);
        chk("write_we_count", 32'(we_edges.size()), 32'd1);
        chk("write_we_cycle", 32'(we_edges[0]), 32'(last_pop));
        chk("write_k_cycle",  32'(tx_edges[0]), 32'(last_pop + 1));

        // Read frame.
        start_test();
        bus.mem_rdata = 32'h12345678;
        exp_mem.push_back('{we: 1'b0, addr: 14'd4, data: 32'h0});
        exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
        foreach (f_r[i]) feed(f_r[i]);
        drain(100, "read");
        chk("read_re_count", 32'(re_edges.size()), 32'd1);
        chk("read_re_cycle", 32'(re_edges[0]), 32'(last_pop));
        chk("read_we_count", 32'(we_edges.size()), 32'd0);
        chk("read_tx_count", 32'(tx_edges.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("read_tx_cycle", 32'(tx_edges[i]), 32'(last_pop + 2 + i));

        // Go, hold, bad command.
        chk("hold_still_set", 32'(bus.cpu_hold), 32'd1);
        start_test();
        exp_tx.push_back(8'h4B);
        feed(8'h47);
        wait_pops(1, 10);
        chk("go_first_pop", 32'(first_pop), 32'(feed_edge + 1));
        chk("go_hold", 32'(bus.cpu_hold), 32'd0);
        drain(50, "go");
        chk("go_k_cycle", 32'(tx_edges[0]), 32'(last_pop + 1));

        start_test();
        exp_tx.push_back(8'h4B);
        feed(8'h48);
        wait_pops(1, 10);
        chk("halt_hold", 32'(bus.cpu_hold), 32'd1);
        drain(50, "halt");
        chk("halt_k_cycle", 32'(tx_edges[0]), 32'(last_pop + 1));

        start_test();
        exp_tx.push_back(8'h3F);
        feed(8'h00);
        drain(50, "bad");
        chk("bad_tx_count", 32'(tx_edges.size()), 32'd1);
        chk("bad_hold", 32'(bus.cpu_hold), 32'd1);

        // Read under TX backpressure; address bits [1:0] and above bit 15 ignored.
        start_test();
        bus.tx_full   = 1'b1;
        bus.mem_rdata = 32'hA5C30F96;
        exp_mem.push_back('{we: 1'b0, addr: 14'h0008, data: 32'h0});
        exp_tx.push_back(8'h96); exp_tx.push_back(8'h0F);
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'hA5);
        chk("bp_first_pop_ready", 32'(bus.rd_uart), 32'd0);
        foreach (f_rb[i]) feed(f_rb[i]);
        repeat (50) tick();
        chk("bp_no_push", 32'(tx_edges.size()), 32'd0);
        chk("bp_re_count", 32'(re_edges.size()), 32'd1);
        chk("bp_first_pop", 32'(first_pop), 32'(feed_edge + 1));
        bus.tx_full = 1'b0;
        drain(50, "bp");
        chk("bp_tx_count", 32'(tx_edges.size()), 32'd4);
        chk("bp_tx_span", 32'(tx_edges[3] - tx_edges[0]), 32'd3);

        // Inter-byte timeout aborts a write frame.
        start_test();
        exp_tx.push_back(8'h21);
        feed(8'h57);
        feed(8'h01);
        begin
            int n;
            n = 0;
            while (tx_edges.size() == 0 && n < 60) begin
                tick();
                n++;
            end
        end
        chk("to_pops",  32'(n_pop), 32'd2);
        chk("to_delay", 32'(tx_edges[0] - last_pop), 32'd16);
        drain(20, "to");
        chk("to_no_we", 32'(we_edges.size() + re_edges.size()), 32'd0);

        start_test();
        exp_tx.push_back(8'h4B);
        feed(8'h47);
        drain(50, "to_next");
        chk("to_next_pop",  32'(first_pop), 32'(feed_edge + 1));
        chk("to_next_hold", 32'(bus.cpu_hold), 32'd0);
        chk("to_next_tx",   32'(tx_edges.size()), 32'd1);

        // Reset in the middle of a write frame.
        start_test();
        feed(8'h57);
        feed(8'hAA);
        wait_pops(2, 10);
        chk("rst_pops", 32'(n_pop), 32'd2);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_values("midreset");
        repeat (30) tick();
        chk("midreset_no_tx", 32'(tx_edges.size()), 32'd0);
        chk("midreset_no_we", 32'(we_edges.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
